// File: rtl/stoch_acc_uni.sv
// ---------------------------------------------------------------------------
// stoch_acc_uni
//
// Windowed popcount accumulator for unipolar stochastic product bitstreams.
// A start request runs one window: a single LOAD cycle that strobes the
// upstream multipliers and clears the accumulator, then 2^WIN_LOG2 RUN
// cycles that add the popcount of iBits, then a single DONE cycle that
// presents the scaled, saturated 8-bit sum with oValid.
//
// Parameters
//   NUM_IN   : number of product bitstreams (default 16)
//   WIN_LOG2 : log2 of the RUN window length in cycles (default 8)
//
// Ports
//   clk     in   1         rising-edge clock
//   rst_n   in   1         asynchronous active-low reset
//   start   in   1         request a window (seen in IDLE and DONE only)
//   iBits   in   NUM_IN    one bit per product stream per cycle
//   oLoad   out  1         load strobe for upstream multipliers (LOAD)
//   oIdx    out  WIN_LOG2  window cycle index / Sobol index
//   oBusy   out  1         high in LOAD and RUN
//   oSum    out  8         scaled result of last completed window
//   oValid  out  1         one-cycle strobe marking a new oSum (DONE)
//
// Build option
//   ACC_ROUND_EN : when defined, the scaled result rounds half up instead
//                  of truncating.
// ---------------------------------------------------------------------------
module stoch_acc_uni #(
    parameter int NUM_IN   = 16,
    parameter int WIN_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_IN-1:0]   iBits,
    output logic                oLoad,
    output logic [WIN_LOG2-1:0] oIdx,
    output logic                oBusy,
    output logic [7:0]          oSum,
    output logic                oValid
);

    localparam int CNT_W = $clog2(NUM_IN + 1);
    localparam int ACC_W = WIN_LOG2 + CNT_W;
    // Full-scale acc is NUM_IN * 2^WIN_LOG2; shifting by this maps it to 256.
    localparam int SHIFT = WIN_LOG2 + $clog2(NUM_IN) - 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef logic [ACC_W:0] acc_ext_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ACC_W-1:0]      r_acc;
    logic [WIN_LOG2-1:0]   r_idx;
    logic [7:0]            r_sum;
    logic [ACC_W-1:0]      w_acc_next;
    logic                  w_last;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_IN-1:0] b);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            c = c + CNT_W'(b[i]);
        end
        return c;
    endfunction

    function automatic logic [7:0] scale_sat(input logic [ACC_W-1:0] a);
        acc_ext_t t;
`ifdef ACC_ROUND_EN
        t = {1'b0, a} + (acc_ext_t'(1) << (SHIFT - 1));
`else
        t = {1'b0, a};
`endif
        t = t >> SHIFT;
        if (t > acc_ext_t'(255)) begin
            return 8'hFF;
        end
        return t[7:0];
    endfunction

    // The final RUN cycle's bits are folded in via w_acc_next so oSum is
    // already valid in the DONE cycle.
    assign w_last     = (r_state == S_RUN) && (r_idx == {WIN_LOG2{1'b1}});
    assign w_acc_next = r_acc + ACC_W'(popcount(iBits));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_LOAD;
            S_LOAD: w_state_next = S_RUN;
            S_RUN:  if (w_last) w_state_next = S_DONE;
            S_DONE: w_state_next = start ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_idx <= '0;
            r_sum <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // iBits are not yet meaningful here: upstream is loading.
                    r_acc <= '0;
                    r_idx <= '0;
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    // Natural wrap returns the index to 0 on leaving RUN.
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum <= scale_sat(w_acc_next);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oLoad  = (r_state == S_LOAD);
    assign oBusy  = (r_state == S_LOAD) || (r_state == S_RUN);
    assign oValid = (r_state == S_DONE);
    assign oIdx   = r_idx;
    assign oSum   = r_sum;

endmodule

// File: tb/tb_stoch_acc_uni.sv
module tb_stoch_acc_uni;

    localparam int NUM_IN   = 16;
    localparam int WIN_LOG2 = 8;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [NUM_IN-1:0]   iBits;
    logic                oLoad;
    logic [WIN_LOG2-1:0] oIdx;
    logic                oBusy;
    logic [7:0]          oSum;
    logic                oValid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] sum;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    stoch_acc_uni #(
        .NUM_IN  (NUM_IN),
        .WIN_LOG2(WIN_LOG2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .iBits (iBits),
        .oLoad (oLoad),
        .oIdx  (oIdx),
        .oBusy (oBusy),
        .oSum  (oSum),
        .oValid(oValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hand-set expected results for each stimulus mode.
    localparam logic [7:0] EXP_ZERO   = 8'd0;    // acc 0
    localparam logic [7:0] EXP_ONES   = 8'd255;  // acc 4096 -> 256 -> sat
    localparam logic [7:0] EXP_SINGLE = 8'd8;    // acc 128
    localparam logic [7:0] EXP_HALF   = 8'd128;  // acc 2048
`ifdef ACC_ROUND_EN
    localparam logic [7:0] EXP_24     = 8'd2;    // (24+8)>>4
    localparam logic [7:0] EXP_40     = 8'd3;    // (40+8)>>4
`else
    localparam logic [7:0] EXP_24     = 8'd1;    // 24>>4
    localparam logic [7:0] EXP_40     = 8'd2;    // 40>>4
`endif

    function automatic logic [NUM_IN-1:0] pat(input int mode, input int j);
        case (mode)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return (j < 128) ? 16'h0001 : 16'h0000;
            3: return (j < 12)  ? 16'h0003 : 16'h0000;
            4: return 16'h00FF;
            5: return (j < 20)  ? 16'h0003 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor: every oValid pops one expectation and checks value and cycle.
    always @(negedge clk) begin
        if (rst_n && oValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: oSum %0d at cycle %0d, none expected", oSum, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("osum", int'(oSum), int'(e.sum));
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    // Called in the cycle where start is to be sampled (IDLE or DONE);
    // returns in the DONE cycle of the window with start = keep_start.
    task automatic do_window(input int mode, input bit keep_start, input logic [7:0] exp_sum);
        exp_t e;
        start = 1'b1;
        e.sum = exp_sum;
        e.cyc = cyc + 258;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = keep_start;
        iBits = 16'hFFFF;   // LOAD-cycle bits must be ignored
        @(negedge clk);
        chk("load_oLoad", int'(oLoad), 1);
        chk("load_oIdx", int'(oIdx), 0);
        chk("load_oBusy", int'(oBusy), 1);
        for (int j = 0; j < 256; j++) begin
            @(posedge clk); #1;
            iBits = pat(mode, j);
            if (j == 100) begin
                @(negedge clk);
                chk("run_oIdx", int'(oIdx), 100);
                chk("run_oLoad", int'(oLoad), 0);
                chk("run_oBusy", int'(oBusy), 1);
            end
        end
        @(posedge clk); #1;
        iBits = '0;
    endtask

    task automatic to_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        iBits = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oLoad", int'(oLoad), 0);
        chk("rst_oBusy", int'(oBusy), 0);
        chk("rst_oValid", int'(oValid), 0);
        chk("rst_oSum", int'(oSum), 0);
        chk("rst_oIdx", int'(oIdx), 0);
        rst_n = 1'b1;

        // Start in the very first cycle after reset release.
        do_window(0, 1'b0, EXP_ZERO);
        to_idle();
        do_window(1, 1'b0, EXP_ONES);
        to_idle();
        do_window(2, 1'b0, EXP_SINGLE);
        to_idle();
        do_window(3, 1'b0, EXP_24);
        to_idle();
        do_window(4, 1'b0, EXP_HALF);
        to_idle();
        do_window(5, 1'b0, EXP_40);
        to_idle();

        // Back-to-back: start held through the first window.
        do_window(4, 1'b1, EXP_HALF);
        do_window(3, 1'b0, EXP_24);
        to_idle();
        @(negedge clk);
        chk("idle_after_b2b_busy", int'(oBusy), 0);
        @(posedge clk); #1;

        // Reset in the middle of RUN.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j <= 100; j++) begin
            @(posedge clk); #1;
            iBits = 16'hFFFF;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_oLoad", int'(oLoad), 0);
        chk("midrst_oBusy", int'(oBusy), 0);
        chk("midrst_oValid", int'(oValid), 0);
        chk("midrst_oSum", int'(oSum), 0);
        chk("midrst_oIdx", int'(oIdx), 0);
        iBits = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_window(2, 1'b0, EXP_SINGLE);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pending_expectations", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
